// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains a byte FIFO and packs bytes little-endian into
// BYTES-wide words presented on a VALID/READY handshake. FLUSH emits a
// trailing partial word with byte enables marking the filled lanes.
// Optional: define WORD_CNT_EN to add WORD_CNT / PARTIAL_CNT transfer counters.
module fifo_word_packer #(
  parameter int BYTES = 4,
  parameter int CW    = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         FIFO_DOUT,
  input  logic               FIFO_EF,
  output logic               FIFO_RE,
  input  logic               FLUSH,
  output logic [8*BYTES-1:0] WORD,
  output logic [BYTES-1:0]   BE,
  output logic               VALID,
  input  logic               READY,
  output logic               BUSY
`ifdef WORD_CNT_EN
  ,
  output logic [15:0]        WORD_CNT,
  output logic [7:0]         PARTIAL_CNT
`endif
);

  typedef enum logic {FILL, OUT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*BYTES-1:0] word_q, word_d;
  logic [BYTES-1:0]   be_q, be_d;
  logic               re;

  // State, lane counter and word/enable registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      be_q    <= be_d;
    end
  end

  // Next state: reads take priority over flush; a full lane set forces OUT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    be_d    = be_q;
    re      = 1'b0;
    case (state_q)
      FILL: begin
        re = ~FIFO_EF;
        if (re) begin
          for (int k = 0; k < BYTES; k++)
            if (cnt_q == CW'(k)) word_d[k*8 +: 8] = FIFO_DOUT;
          if (cnt_q == CW'(BYTES-1)) begin
            state_d = OUT;
            be_d    = '1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (FLUSH && (cnt_q != '0)) begin
          state_d = OUT;
          for (int k = 0; k < BYTES; k++) be_d[k] = (CW'(k) < cnt_q);
          cnt_d = '0;
        end
      end
      OUT: begin
        if (READY) begin
          state_d = FILL;
          word_d  = '0;
          be_d    = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign FIFO_RE = RESET & re;
  assign VALID   = (state_q == OUT);
  assign WORD    = word_q;
  assign BE      = be_q;
  assign BUSY    = (cnt_q != '0) | VALID;

`ifdef WORD_CNT_EN
  logic [15:0] wcnt_q;
  logic [7:0]  pcnt_q;

  // Transfer counters: total wraps, partial-word count saturates
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wcnt_q <= '0;
      pcnt_q <= '0;
    end else if (VALID && READY) begin
      wcnt_q <= wcnt_q + 16'd1;
      if ((be_q != '1) && (pcnt_q != 8'hFF)) pcnt_q <= pcnt_q + 8'd1;
    end
  end

  assign WORD_CNT    = wcnt_q;
  assign PARTIAL_CNT = pcnt_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (BYTES=4) with a queue-based FIFO model.
module tb_fifo_word_packer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  FIFO_DOUT;
  logic        FIFO_EF;
  logic        FIFO_RE;
  logic        FLUSH;
  logic [31:0] WORD;
  logic [3:0]  BE;
  logic        VALID;
  logic        READY;
  logic        BUSY;
`ifdef WORD_CNT_EN
  logic [15:0] WORD_CNT;
  logic [7:0]  PARTIAL_CNT;
`endif

  fifo_word_packer #(.BYTES(4), .CW(3)) dut (
    .CLK(CLK), .RESET(RESET), .FIFO_DOUT(FIFO_DOUT), .FIFO_EF(FIFO_EF),
    .FIFO_RE(FIFO_RE), .FLUSH(FLUSH), .WORD(WORD), .BE(BE), .VALID(VALID),
    .READY(READY), .BUSY(BUSY)
`ifdef WORD_CNT_EN
    , .WORD_CNT(WORD_CNT), .PARTIAL_CNT(PARTIAL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0]  fq[$];
  logic [31:0] xw[$];
  logic [3:0]  xb[$];
  logic        re_q = 1'b0;
  int          re_cnt = 0;
  int          vld_cycles = 0;

  // Edge monitor: read strobes, VALID-high cycles, completed transfers
  always @(posedge CLK) begin
    re_q <= FIFO_RE;
    if (FIFO_RE) re_cnt <= re_cnt + 1;
    if (VALID) vld_cycles <= vld_cycles + 1;
    if (RESET && VALID && READY) begin
      xw.push_back(WORD);
      xb.push_back(BE);
    end
  end

  task automatic drive();
    FIFO_EF   = (fq.size() == 0);
    FIFO_DOUT = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    drive();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (re_q && fq.size() != 0) void'(fq.pop_front());
    drive();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int base_re, base_x;
  logic [31:0] hw;
  logic [3:0]  hb;

  initial begin
    RESET = 1'b0; FLUSH = 1'b0; READY = 1'b1;
    FIFO_EF = 1'b1; FIFO_DOUT = 8'h00;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);

    // Reset with FIFO non-empty
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_re", FIFO_RE, 1'b0);
      chk("rst_valid", VALID, 1'b0);
      chk("rst_be", BE, 4'h0);
      chk("rst_word", WORD, 32'h0);
      chk("rst_busy", BUSY, 1'b0);
    end
    RESET = 1'b1;
    #1;
    chk("rel_re", FIFO_RE, 1'b1);
    base_re = re_cnt; base_x = xw.size(); vld_cycles = 0;

    // Full word, READY high
    for (int i = 0; i < 4; i++) tick();
    chk("full_valid", VALID, 1'b1);
    chk("full_word", WORD, 32'h44332211);
    chk("full_be", BE, 4'hF);
    chk("full_re_out", FIFO_RE, 1'b0);
    tick();
    chk("full_valid_drop", VALID, 1'b0);
    chk("full_reads", re_cnt - base_re, 4);
    chk("full_vld_cycles", vld_cycles, 1);
    chk("full_xfers", xw.size() - base_x, 1);
    if (xw.size() > base_x) chk("full_xword", xw[base_x], 32'h44332211);

    // Backpressure: word held for 10 cycles while the FIFO has data
    READY = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    base_x = xw.size();
    for (int i = 0; i < 4; i++) tick();
    chk("bp_valid", VALID, 1'b1);
    hw = WORD; hb = BE;
    chk("bp_word", hw, 32'h88776655);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_word", WORD, hw);
      chk("bp_hold_be", BE, hb);
      chk("bp_re", FIFO_RE, 1'b0);
    end
    READY = 1'b1;
    tick();
    chk("bp_xfer_drop", VALID, 1'b0);
    chk("bp_refill_re", FIFO_RE, 1'b1);
    chk("bp_xfers", xw.size() - base_x, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_word2", WORD, 32'h04030201);
    tick();

    // Flush of a two-byte partial word
    push(8'hA5); push(8'h5A);
    base_x = xw.size();
    tick(); tick();
    chk("fl_ef", FIFO_EF, 1'b1);
    chk("fl_busy", BUSY, 1'b1);
    chk("fl_novalid", VALID, 1'b0);
    FLUSH = 1'b1;
    tick();
    chk("fl_valid", VALID, 1'b1);
    chk("fl_word", WORD, 32'h00005AA5);
    chk("fl_be", BE, 4'h3);
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fl_idle_valid", VALID, 1'b0);
    end
    chk("fl_xfers", xw.size() - base_x, 1);
    chk("fl_idle_busy", BUSY, 1'b0);

    // Flush held while 6 bytes are available
    base_x = xw.size(); base_re = re_cnt;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
    for (int i = 0; i < 12; i++) tick();
    chk("fp_xfers", xw.size() - base_x, 2);
    chk("fp_reads", re_cnt - base_re, 6);
    if (xw.size() >= base_x + 2) begin
      chk("fp_word0", xw[base_x], 32'hC4C3C2C1);
      chk("fp_be0", xb[base_x], 4'hF);
      chk("fp_word1", xw[base_x+1], 32'h0000C6C5);
      chk("fp_be1", xb[base_x+1], 4'h3);
    end
    FLUSH = 1'b0;

    // Reset mid-fill discards the partial bytes
    push(8'hD1); push(8'hD2); push(8'hD3);
    tick(); tick(); tick();
    chk("mr_busy_pre", BUSY, 1'b1);
    RESET = 1'b0;
    tick();
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_valid", VALID, 1'b0);
    RESET = 1'b1;
    base_x = xw.size();
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    for (int i = 0; i < 5; i++) tick();
    chk("mr_xfers", xw.size() - base_x, 1);
    if (xw.size() > base_x) begin
      chk("mr_word", xw[base_x], 32'hB3B2B1B0);
      chk("mr_be", xb[base_x], 4'hF);
    end
`ifdef WORD_CNT_EN
    chk("mr_word_cnt", WORD_CNT, 16'd1);
    chk("mr_partial_cnt", PARTIAL_CNT, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 16x8 byte FIFO.
- Drains bytes using the FIFO's empty flag and read-enable, and packs them little-endian into BYTES-wide words.
- Presents each word on a VALID/READY output handshake toward the next stage (bus or DMA writer).
- A FLUSH request emits a trailing partial word, with per-byte enables marking which lanes hold data.

Parameters:
- BYTES, 4, bytes per output word; legal range 2..8.
- CW, 3, width of the internal byte counter; must satisfy 2**CW >= BYTES.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-low reset.
- FIFO_DOUT  input  8  FIFO read data; the byte at the current read pointer, valid whenever FIFO_EF=0.
- FIFO_EF  input  1  FIFO empty flag; 1 = no readable byte.
- FIFO_RE  output  1  FIFO read enable; one byte consumed per cycle it is high.
- FLUSH  input  1  level request to emit a partial word once the FIFO runs empty.
- WORD  output  8*BYTES  packed word; byte k in bits [8k+7:8k], with the first byte read in lane 0.
- BE  output  BYTES  byte enables for WORD; bit k=1 means lane k holds data.
- VALID  output  1  WORD/BE valid.
- READY  input  1  consumer accepts the word when VALID & READY at a clock edge.
- BUSY  output  1  1 when any byte is held (partial fill or word pending).

Behaviour:
- Reset (RESET=0 at an edge), applied the same way regardless of current state:
  - state=FILL, cnt=0, WORD=0, BE=0, VALID=0, BUSY=0.
  - Any partially packed bytes or pending word are discarded.
  - FIFO_RE=0 while RESET=0.
- State FILL:
  - FIFO_RE = ~FIFO_EF (combinational; never asserted while FIFO_EF=1).
  - On an edge with FIFO_RE=1: lane cnt <- FIFO_DOUT.
    - If cnt<BYTES-1: cnt <- cnt+1.
    - If cnt=BYTES-1: go to OUT with BE all ones and cnt <- 0.
  - On an edge with FIFO_RE=0, FLUSH=1 and cnt>0: go to OUT with BE=(1<<cnt)-1 and cnt <- 0. Unfilled lanes read 0.
  - FLUSH with cnt=0 and FIFO empty: no action.
  - FLUSH while FIFO non-empty: reading continues. A flush takes effect only when the FIFO is empty, so reads have priority over flush.
- State OUT:
  - VALID=1 and FIFO_RE=0.
  - WORD/BE are stable until transfer.
  - On an edge with READY=1: WORD <- 0, BE <- 0, VALID <- 0, go to FILL.
  - READY=0: hold indefinitely; the FIFO backs up, with its full flag handled upstream.
- Latency and throughput:
  - VALID rises the cycle after the edge that captures the last byte (or the flush edge).
  - With READY held at 1, sustained rate is one word per BYTES+1 cycles.
- BUSY = (cnt!=0) | VALID.
- cnt never exceeds BYTES-1. No wrap-around is possible because a full lane set forces OUT.
- FIFO_EF toggling while in OUT has no effect.

Optional Feature:
- Macro WORD_CNT_EN.
- Defined:
  - Adds output WORD_CNT [15:0], reset to 0 with the synchronous reset.
  - Increments by 1 on every VALID & READY transfer, partial words included.
  - Wraps from 16'hFFFF to 0.
  - Adds output PARTIAL_CNT [7:0], which increments on transfers with BE not all ones and saturates at 8'hFF.
- Undefined:
  - Neither port nor counter exists.
  - The functional behaviour of all other ports is identical.

Test Plan (BYTES=4):
- Reset: drive RESET=0 for 2 cycles with FIFO_EF=0 -> FIFO_RE=0, VALID=0, BE=0, WORD=0 during reset; FIFO_RE=1 in the first cycle after RESET=1.
- Full word: FIFO supplies 8'h11,22,33,44 back-to-back with READY=1 -> VALID for exactly 1 cycle, WORD=32'h44332211, BE=4'hF, FIFO_RE high for exactly 4 cycles.
- Backpressure: same bytes with READY=0 for 10 cycles, then 1 -> WORD/BE held constant, FIFO_RE=0 throughout; transfer on the first READY=1 edge; next fill starts the following cycle.
- Flush: bytes 8'hA5,8'h5A, then FIFO_EF=1 and FLUSH=1 -> WORD=32'h00005AA5, BE=4'h3. FLUSH held with the FIFO empty afterwards -> no further VALID.
- Flush with data pending: FLUSH=1 while 6 bytes are available -> one full word (BE=F), then a partial word (BE=3); no read is skipped.
- Reset mid-fill: RESET=0 after 3 bytes, then 4 new bytes B0..B3 -> single word 32'hB3B2B1B0, BE=F. With WORD_CNT_EN: WORD_CNT=1 and PARTIAL_CNT=0 after the transfer.
